// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, derived totals
// and the axis FSM state shared by the VGA timing generator.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    ACT,
    FRONT,
    SYNC,
    BACK
  } axis_state_e;

  // Sync pin level for an asserted/deasserted pulse.
  function automatic logic sync_level(
    input logic active,
    input logic pol
  );
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (H or V) -- position
// counter plus ACT/FRONT/SYNC/BACK region tracker.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC_W = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             run_i,
  input  logic             step_i,
  output logic [CNT_W-1:0] cnt_o,
  output axis_state_e      state_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC_W + BP;

  localparam logic [CNT_W-1:0] L_ACT =
    CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] L_FP =
    CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] L_SYNC =
    CNT_W'(ACTIVE + FP + SYNC_W - 1);
  localparam logic [CNT_W-1:0] L_TOT =
    CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  axis_state_e      state_q, state_d;

  // Position and region registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      state_q <= ACT;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Advance on step; idle forces the origin so a
  // restart always begins a fresh frame.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (!run_i) begin
      cnt_d   = '0;
      state_d = ACT;
    end else if (step_i) begin
      cnt_d = (cnt_q == L_TOT) ? '0 : cnt_q + 1'b1;
      unique case (state_q)
        ACT:   if (cnt_q == L_ACT)  state_d = FRONT;
        FRONT: if (cnt_q == L_FP)   state_d = SYNC;
        SYNC:  if (cnt_q == L_SYNC) state_d = BACK;
        BACK:  if (cnt_q == L_TOT)  state_d = ACT;
        default:                    state_d = ACT;
      endcase
    end
  end

  assign cnt_o   = cnt_q;
  assign state_o = state_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with pixel request and a
// 2-stage aligned output pipeline. Option: VGA_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             pix_req,
  input  logic [2:0]       pix_rgb,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             test_mode,
`endif
  output logic [2:0]       rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(H_TOTAL - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  axis_state_e      h_st, v_st;
  logic             h_wrap;

  assign h_wrap = (h_cnt == H_LAST);

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC_W (H_SYNC),
    .BP     (H_BP)
  ) u_h (
    .clk_i   (clk_pixel),
    .reset_i (reset),
    .run_i   (enable),
    .step_i  (1'b1),
    .cnt_o   (h_cnt),
    .state_o (h_st)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC_W (V_SYNC),
    .BP     (V_BP)
  ) u_v (
    .clk_i   (clk_pixel),
    .reset_i (reset),
    .run_i   (enable),
    .step_i  (h_wrap),
    .cnt_o   (v_cnt),
    .state_o (v_st)
  );

  // Stage 0: pixel address plus the raster flags for it.
  logic [CNT_W-1:0] pix_x_q, pix_y_q;
  logic req_q, hs0_q, vs0_q, fs0_q;
  logic req_d, hs0_d, vs0_d, fs0_d;
  // Stage 1: waits for upstream pixel data.
  logic de1_q, hs1_q, vs1_q, fs1_q;
  // Stage 2: outputs to the encoder.
  logic [2:0] rgb_q, rgb_src;
  logic de_q, hsync_q, vsync_q, fs_q;

  // Raster flags for the current counter position.
  always_comb begin
    req_d = enable && (h_st == ACT) && (v_st == ACT);
    hs0_d = enable && (h_st == SYNC);
    vs0_d = enable && (v_st == SYNC);
    fs0_d = enable && (h_cnt == '0) && (v_cnt == '0);
  end

  // Address stage and flag delay line.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      pix_x_q <= '0;
      pix_y_q <= '0;
      req_q   <= 1'b0;
      hs0_q   <= 1'b0;
      vs0_q   <= 1'b0;
      fs0_q   <= 1'b0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      fs1_q   <= 1'b0;
    end else begin
      pix_x_q <= h_cnt;
      pix_y_q <= v_cnt;
      req_q   <= req_d;
      hs0_q   <= hs0_d;
      vs0_q   <= vs0_d;
      fs0_q   <= fs0_d;
      de1_q   <= req_q;
      hs1_q   <= hs0_q;
      vs1_q   <= vs0_q;
      fs1_q   <= fs0_q;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W =
    CNT_W'(H_ACTIVE / 8);

  logic [2:0] bar_d, bar1_q;

  // Colour bar for the addressed column, brightest first.
  always_comb begin
    bar_d = 3'd7 - 3'(pix_x_q / BAR_W);
  end

  // Bar delayed to line up with upstream pixel data.
  always_ff @(posedge clk_pixel) begin
    if (reset) bar1_q <= 3'b000;
    else       bar1_q <= bar_d;
  end
`endif

  // Pixel source: upstream data or the built-in bars.
  always_comb begin
    rgb_src = pix_rgb;
`ifdef VGA_TEST_PATTERN_EN
    if (test_mode) rgb_src = bar1_q;
`endif
  end

  // Output register; blanking forces black.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      rgb_q   <= 3'b000;
      de_q    <= 1'b0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      fs_q    <= 1'b0;
    end else begin
      rgb_q   <= de1_q ? rgb_src : 3'b000;
      de_q    <= de1_q;
      hsync_q <= sync_level(hs1_q, SYNC_POL);
      vsync_q <= sync_level(vs1_q, SYNC_POL);
      fs_q    <= fs1_q;
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_req     = req_q;
  assign rgb         = rgb_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized bench for vga_timing_gen
// against a position-arithmetic raster model (small timing).
module tb_vga_timing_gen;

  localparam int HA = 32, HF = 4, HS = 6, HB = 6;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam logic POL = 1'b0;

  logic       clk_pixel = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [9:0] pix_x, pix_y;
  logic       pix_req;
  logic [2:0] pix_rgb = 3'b000;
  logic [2:0] rgb;
  logic       hsync, vsync, de, frame_start;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_mode = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_pixel = ~clk_pixel;

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF),
    .H_SYNC   (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF),
    .V_SYNC   (VS), .V_BP (VB),
    .SYNC_POL (POL)
  ) dut (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .enable      (enable),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_req     (pix_req),
    .pix_rgb     (pix_rgb),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode   (test_mode),
`endif
    .rgb         (rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .frame_start (frame_start)
  );

  // Model: a raster position is just "cycles since the run
  // started" folded into (x, y); outputs trail it by 2 cycles.
  typedef struct {
    bit v;
    int px;
    int py;
  } ent_t;

  ent_t       s0 = '{0, 0, 0};
  ent_t       s1 = '{0, 0, 0};
  int         run_len = 0;
  int         rgb_mode = 0;
  logic [2:0] last_px3 = 3'b000;
  logic [9:0] e_px = '0, e_py = '0;
  logic       e_req = 1'b0;
  logic [2:0] e_rgb = 3'b000;
  logic       e_de = 1'b0, e_fs = 1'b0;
  logic       e_hs = ~POL, e_vs = ~POL;

  function automatic bit vis(ent_t e);
    return e.v && e.px < HA && e.py < VA;
  endfunction

  task automatic step();
    @(posedge clk_pixel);
    if (reset) begin
      s0 = '{0, 0, 0};
      s1 = '{0, 0, 0};
      run_len = 0;
      e_de = 1'b0;
      e_rgb = 3'b000;
      e_hs = ~POL;
      e_vs = ~POL;
      e_fs = 1'b0;
    end else begin
      e_de  = vis(s1);
      e_rgb = e_de ? pix_rgb : 3'b000;
`ifdef VGA_TEST_PATTERN_EN
      if (e_de && test_mode)
        e_rgb = 3'(7 - s1.px / (HA / 8));
`endif
      e_hs = (s1.v && s1.px >= HA + HF &&
              s1.px < HA + HF + HS) ? POL : ~POL;
      e_vs = (s1.v && s1.py >= VA + VF &&
              s1.py < VA + VF + VS) ? POL : ~POL;
      e_fs = s1.v && s1.px == 0 && s1.py == 0;
      s1 = s0;
      s0.v  = enable;
      s0.px = run_len % HT;
      s0.py = run_len / HT;
      run_len = enable ? (run_len + 1) % FR : 0;
    end
    e_px  = 10'(s0.px);
    e_py  = 10'(s0.py);
    e_req = vis(s0);
    #1;
    case (rgb_mode)
      0:       pix_rgb = 3'($urandom_range(0, 7));
      1:       pix_rgb = 3'b101;
      default: pix_rgb = last_px3;
    endcase
    last_px3 = e_px[2:0];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({pix_x, pix_y, pix_req, rgb, de,
           hsync, vsync, frame_start} !==
          {10'd0, 10'd0, 1'b0, 3'b000, 1'b0,
           ~POL, ~POL, 1'b0}) begin
        errors++;
        $display("FAIL reset_vals: got x=%0d y=%0d req=%b rgb=%b de=%b hs=%b vs=%b fs=%b, need all idle",
                 pix_x, pix_y, pix_req, rgb, de,
                 hsync, vsync, frame_start);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_frames();
    int hs_low, vs_low, de_hi;
    hs_low = 0;
    vs_low = 0;
    de_hi = 0;
    rgb_mode = 0;
    enable = 1'b1;
    for (int i = 0; i < 2 * FR + 2; i++) begin
      step();
      if (i >= 2) begin
        hs_low += (hsync == POL) ? 1 : 0;
        vs_low += (vsync == POL) ? 1 : 0;
        de_hi  += de ? 1 : 0;
      end
      checks++;
      if ({pix_x, pix_y, pix_req} !==
          {e_px, e_py, e_req}) begin
        errors++;
        $display("FAIL frames_pix: got (%0d,%0d) req=%b, need (%0d,%0d) req=%b",
                 pix_x, pix_y, pix_req, e_px, e_py, e_req);
      end
      checks++;
      if ({rgb, de, hsync, vsync, frame_start} !==
          {e_rgb, e_de, e_hs, e_vs, e_fs}) begin
        errors++;
        $display("FAIL frames_out: got rgb=%b de=%b hs=%b vs=%b fs=%b, need %b %b %b %b %b",
                 rgb, de, hsync, vsync, frame_start,
                 e_rgb, e_de, e_hs, e_vs, e_fs);
      end
    end
    checks++;
    if (hs_low != 2 * VT * HS) begin
      errors++;
      $display("FAIL hsync_count: got %0d, need %0d",
               hs_low, 2 * VT * HS);
    end
    checks++;
    if (vs_low != 2 * VS * HT) begin
      errors++;
      $display("FAIL vsync_count: got %0d, need %0d",
               vs_low, 2 * VS * HT);
    end
    checks++;
    if (de_hi != 2 * HA * VA) begin
      errors++;
      $display("FAIL de_count: got %0d, need %0d",
               de_hi, 2 * HA * VA);
    end
  endtask

  task automatic test_const_rgb();
    int n101;
    n101 = 0;
    rgb_mode = 1;
    step();
    for (int i = 0; i < FR; i++) begin
      step();
      n101 += (rgb == 3'b101) ? 1 : 0;
      checks++;
      if ((rgb == 3'b101) !== de ||
          (!de && rgb !== 3'b000)) begin
        errors++;
        $display("FAIL const_rgb: got rgb=%b de=%b, need rgb=101 iff de, else 000",
                 rgb, de);
      end
    end
    checks++;
    if (n101 != HA * VA) begin
      errors++;
      $display("FAIL const_count: got %0d, need %0d",
               n101, HA * VA);
    end
  endtask

  task automatic test_alignment();
    int i;
    rgb_mode = 2;
    i = 0;
    while (i < FR + 8 && !(e_fs && i >= 3)) begin
      step();
      i++;
    end
    checks++;
    if (!(e_fs && i >= 3)) begin
      errors++;
      $display("FAIL align_wait: got no frame start in %0d cycles, need one",
               FR + 8);
    end else begin
      for (int k = 0; k < 9; k++) begin
        if (k > 0) step();
        checks++;
        if ({rgb, de, frame_start} !==
            {3'(k % 8), 1'b1, (k == 0)}) begin
          errors++;
          $display("FAIL align_seq%0d: got rgb=%0d de=%b fs=%b, need rgb=%0d de=1 fs=%b",
                   k, rgb, de, frame_start, k % 8,
                   (k == 0));
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    int i;
    rgb_mode = 0;
    i = 0;
    while (i < FR + 4 &&
           !(e_px == HA / 2 && e_py == VA / 2)) begin
      step();
      i++;
    end
    checks++;
    if (!(e_px == HA / 2 && e_py == VA / 2)) begin
      errors++;
      $display("FAIL drop_wait: got no pixel (%0d,%0d), need one",
               HA / 2, VA / 2);
    end
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (pix_req !== 1'b0 ||
          (k >= 2 && {de, rgb} !== 4'b0)) begin
        errors++;
        $display("FAIL drop_idle%0d: got req=%b de=%b rgb=%b, need req=0 (de=0 rgb=0 from 2)",
                 k, pix_req, de, rgb);
      end
      checks++;
      if ({rgb, de, hsync, vsync, frame_start} !==
          {e_rgb, e_de, e_hs, e_vs, e_fs}) begin
        errors++;
        $display("FAIL drop_out: got %b %b %b %b %b, need %b %b %b %b %b",
                 rgb, de, hsync, vsync, frame_start,
                 e_rgb, e_de, e_hs, e_vs, e_fs);
      end
    end
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({pix_req, frame_start} !==
          {1'b1, (k == 2)}) begin
        errors++;
        $display("FAIL restart%0d: got req=%b fs=%b, need req=1 fs=%b",
                 k, pix_req, frame_start, (k == 2));
      end
      if (k == 0) begin
        checks++;
        if ({pix_x, pix_y} !== 20'd0) begin
          errors++;
          $display("FAIL restart_xy: got (%0d,%0d), need (0,0)",
                   pix_x, pix_y);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int i;
    i = 0;
    while (i < FR + 4 &&
           !(e_px == HA + HF + 1 &&
             e_py == VA + VF + 1)) begin
      step();
      i++;
    end
    checks++;
    if (!(e_px == HA + HF + 1 && e_py == VA + VF + 1)) begin
      errors++;
      $display("FAIL midrst_wait: got no sync-region pixel, need one");
    end
    reset = 1'b1;
    step();
    checks++;
    if ({pix_x, pix_y, pix_req, rgb, de,
         hsync, vsync, frame_start} !==
        {10'd0, 10'd0, 1'b0, 3'b000, 1'b0,
         ~POL, ~POL, 1'b0}) begin
      errors++;
      $display("FAIL midrst_vals: got x=%0d y=%0d req=%b rgb=%b de=%b hs=%b vs=%b fs=%b, need all idle",
               pix_x, pix_y, pix_req, rgb, de,
               hsync, vsync, frame_start);
    end
    reset = 1'b0;
    for (int k = 0; k < 2 * HT; k++) begin
      step();
      checks++;
      if ({pix_x, pix_y, pix_req, rgb, de,
           hsync, vsync, frame_start} !==
          {e_px, e_py, e_req, e_rgb, e_de,
           e_hs, e_vs, e_fs}) begin
        errors++;
        $display("FAIL midrst_run: got (%0d,%0d) %b %b %b %b %b %b, need (%0d,%0d) %b %b %b %b %b %b",
                 pix_x, pix_y, pix_req, rgb, de,
                 hsync, vsync, frame_start,
                 e_px, e_py, e_req, e_rgb, e_de,
                 e_hs, e_vs, e_fs);
      end
    end
  endtask

  task automatic test_random_ctrl();
    rgb_mode = 0;
    for (int k = 0; k < 3000; k++) begin
      reset  = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 39) != 0);
      step();
      checks++;
      if ({pix_x, pix_y, pix_req, rgb, de,
           hsync, vsync, frame_start} !==
          {e_px, e_py, e_req, e_rgb, e_de,
           e_hs, e_vs, e_fs}) begin
        errors++;
        $display("FAIL random_ctrl: got (%0d,%0d) %b %b %b %b %b %b, need (%0d,%0d) %b %b %b %b %b %b",
                 pix_x, pix_y, pix_req, rgb, de,
                 hsync, vsync, frame_start,
                 e_px, e_py, e_req, e_rgb, e_de,
                 e_hs, e_vs, e_fs);
      end
    end
    reset = 1'b0;
    enable = 1'b1;
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    int i;
    rgb_mode = 0;
    test_mode = 1'b1;
    enable = 1'b1;
    i = 0;
    while (i < FR + 8 && !(e_fs && i >= 3)) begin
      step();
      i++;
    end
    for (int k = 0; k < HT; k++) begin
      if (k > 0) step();
      checks++;
      if (rgb !== (k < HA ?
                   3'(7 - k / (HA / 8)) : 3'b000)) begin
        errors++;
        $display("FAIL pattern%0d: got %b, need %b",
                 k, rgb, (k < HA ?
                          3'(7 - k / (HA / 8)) : 3'b000));
      end
    end
    test_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_frames();
    test_const_rgb();
    test_alignment();
    test_enable_drop();
    test_reset_midframe();
    test_random_ctrl();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
